// File: rtl/systolic_pkg.sv
// Shared types and helpers for the systolic array output-side logic.
//   drain_state_e : drain controller FSM states
//   cnt_width()   : bits needed to hold a count in 0..n
package systolic_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFlush,
    StDrain,
    StFinish,
    StErr
  } drain_state_e;

  function automatic int unsigned cnt_width(input int unsigned n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/systolic_drain_fifo.sv
// Small result FIFO between the systolic array and the host stream.
//   clk_i/reset_i : clock, asynchronous active-low reset
//   push_i/data_i : write an entry (ignored when full)
//   pop_i         : drop the head entry (ignored when empty)
//   clear_i       : discard all entries; wins over push/pop
//   full_o/empty_o: occupancy flags
//   data_o        : head entry, or the last written entry while empty
module systolic_drain_fifo #(
  parameter int unsigned width_p = 9,
  parameter int unsigned els_p   = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               push_i,
  input  logic               pop_i,
  input  logic               clear_i,
  input  logic [width_p-1:0] data_i,
  output logic               full_o,
  output logic               empty_o,
  output logic [width_p-1:0] data_o
);

  localparam int unsigned PtrW = $clog2(els_p);

  // Extra MSB on each pointer separates full from empty.
  logic [PtrW:0]        wr_ptr_q, wr_ptr_d;
  logic [PtrW:0]        rd_ptr_q, rd_ptr_d;
  logic [width_p-1:0]   mem_q [els_p];
  logic                 do_push, do_pop;
  logic [PtrW-1:0]      last_idx;

  always_comb begin
    empty_o  = (wr_ptr_q == rd_ptr_q);
    full_o   = (wr_ptr_q[PtrW] != rd_ptr_q[PtrW]) &&
               (wr_ptr_q[PtrW-1:0] == rd_ptr_q[PtrW-1:0]);
    do_push  = push_i & ~full_o;
    do_pop   = pop_i & ~empty_o;
    last_idx = wr_ptr_q[PtrW-1:0] - PtrW'(1);
    // Hold the most recently written word while empty so the output stays stable.
    data_o   = empty_o ? mem_q[last_idx] : mem_q[rd_ptr_q[PtrW-1:0]];
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (clear_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
    end else begin
      if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_d = rd_ptr_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      for (int i = 0; i < int'(els_p); i++) mem_q[i] <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      if (do_push && !clear_i) mem_q[wr_ptr_q[PtrW-1:0]] <= data_i;
    end
  end

endmodule

// File: rtl/systolic_drain_ctrl.sv
// Output-side consumer for systolic_array: flushes the array, drains a burst
// of array_width_p*array_height_p results through a small FIFO to the host.
//   start_i                         : request a flush+drain burst (IDLE or ERR only)
//   flush_o                         : one-cycle flush pulse to the array
//   arr_valid_i/arr_data_i/arr_yumi_o: array result handshake
//   host_valid_o/host_data_o/host_last_o/host_ready_i: host stream
//   busy_o, done_o, timeout_o, count_o: status
module systolic_drain_ctrl
  import systolic_pkg::*;
#(
  parameter int unsigned width_p        = 8,
  parameter int unsigned array_width_p  = 8,
  parameter int unsigned array_height_p = 8,
  parameter int unsigned els_p          = 4,
  parameter int unsigned timeout_p      = 256,
  localparam int unsigned CntW          = cnt_width(array_width_p * array_height_p)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               start_i,
  output logic               flush_o,
  input  logic               arr_valid_i,
  input  logic [width_p-1:0] arr_data_i,
  output logic               arr_yumi_o,
  output logic               host_valid_o,
  output logic [width_p-1:0] host_data_o,
  output logic               host_last_o,
  input  logic               host_ready_i,
  output logic               busy_o,
  output logic               done_o,
  output logic               timeout_o,
  output logic [CntW-1:0]    count_o
);

  localparam int unsigned N    = array_width_p * array_height_p;
  localparam int unsigned TmoW = $clog2(timeout_p);
  localparam logic [CntW-1:0] NCnt     = CntW'(N);
  localparam logic [CntW-1:0] LastCnt  = CntW'(N - 1);
  localparam logic [TmoW-1:0] TmoLimit = TmoW'(timeout_p - 1);

  drain_state_e      state_q;
  logic [CntW-1:0]   count_q;
  logic [TmoW-1:0]   tmo_q;
  logic              timeout_q;

  logic              fifo_full, fifo_empty, fifo_clear, pop, is_last, head_last;
  logic [width_p:0]  head;

  systolic_drain_fifo #(
    .width_p (width_p + 1),
    .els_p   (els_p)
  ) u_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .push_i  (arr_yumi_o),
    .pop_i   (pop),
    .clear_i (fifo_clear),
    .data_i  ({is_last, arr_data_i}),
    .full_o  (fifo_full),
    .empty_o (fifo_empty),
    .data_o  (head)
  );

  always_comb begin
    is_last      = (count_q == LastCnt);
    arr_yumi_o   = (state_q == StDrain) & arr_valid_i & ~fifo_full;
    host_valid_o = ~fifo_empty;
    head_last    = head[width_p];
    host_last_o  = head_last;
    host_data_o  = head[width_p-1:0];
    pop          = host_valid_o & host_ready_i;
    fifo_clear   = (state_q == StErr) & start_i;
    flush_o      = (state_q == StFlush);
    busy_o       = (state_q != StIdle);
    done_o       = (state_q == StFinish) & pop & head_last;
    timeout_o    = timeout_q;
    count_o      = count_q;
  end

  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state_q   <= StIdle;
      count_q   <= '0;
      tmo_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle, StErr: begin
          if (start_i) begin
            state_q   <= StFlush;
            count_q   <= '0;
            tmo_q     <= '0;
            timeout_q <= 1'b0;
          end
        end
        StFlush: begin
          state_q <= StDrain;
          tmo_q   <= '0;
        end
        StDrain: begin
          if (arr_yumi_o) begin
            tmo_q <= '0;
            if (count_q != NCnt) count_q <= count_q + 1'b1;
            if (is_last) state_q <= StFinish;
          end else if (tmo_q == TmoLimit) begin
            // Full-FIFO stalls count too: a stuck host also ends the burst.
            state_q   <= StErr;
            timeout_q <= 1'b1;
          end else begin
            tmo_q <= tmo_q + 1'b1;
          end
        end
        StFinish: begin
          if (pop && head_last) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: doc/systolic_drain_ctrl.md
Name: systolic_drain_ctrl

Overview:
Output-side consumer for systolic_array. On a start request it pulses flush_o and accepts results over the array's valid/yumi output handshake. It tags the final result of an array_width_p*array_height_p burst and buffers results in a small FIFO. It forwards them to a host over a valid/ready stream, replacing the bench-side flush/drain logic with synthesizable RTL.

Parameters:
width_p, 8, result data width (matches systolic_array width_p)
array_width_p, 8, array columns
array_height_p, 8, array rows
els_p, 4, result FIFO depth (power of two, >=2)
timeout_p, 256, max consecutive DRAIN cycles without an accepted result before error

Ports:
clk_i  in  1  clock
reset_i  in  1  reset, asynchronous, active-low
start_i  in  1  request a flush+drain burst
flush_o  out  1  to array flush_i
arr_valid_i  in  1  from array valid_o
arr_data_i  in  width_p  from array data_o
arr_yumi_o  out  1  to array yumi_i
host_valid_o  out  1  FIFO head valid
host_data_o  out  width_p  FIFO head data
host_last_o  out  1  head entry is result N-1 of the burst
host_ready_i  in  1  host accepts head
busy_o  out  1  state != IDLE
done_o  out  1  one-cycle pulse when the last result is popped by the host
timeout_o  out  1  sticky timeout error
count_o  out  $clog2(N+1)  results accepted this burst

Behaviour:
- N = array_width_p*array_height_p (default 64).
- Reset (reset_i=0, async): state IDLE, FIFO empty, count_o=0, timeout counter=0. All outputs 0.
- States: IDLE, FLUSH, DRAIN, FINISH, ERR.
- IDLE: start_i=1 -> FLUSH. Clear count_o and timeout_o.
- FLUSH: flush_o=1 for exactly one cycle, then unconditionally -> DRAIN.
- DRAIN: arr_yumi_o = arr_valid_i & ~fifo_full, combinational. Only DRAIN asserts yumi.
- Each yumi pushes {last, arr_data_i}, with last = (count_o==N-1), and increments count_o.
- The push with last=1 moves DRAIN -> FINISH on the same edge.
- Timeout counter: resets to 0 on each yumi. Otherwise increments every DRAIN cycle, including full-FIFO stall cycles.
- Timeout counter reaching timeout_p-1 with no yumi -> ERR, timeout_o=1.
- FINISH: arr_yumi_o=0; extra array results are not consumed. When the host pops the last=1 entry, done_o=1 that cycle and FINISH -> IDLE.
- ERR: arr_yumi_o=0. The FIFO keeps draining to the host. timeout_o holds until reset or start_i.
- start_i in ERR: flush the FIFO (empty next cycle), clear timeout_o and count_o, -> FLUSH.
- start_i in FLUSH, DRAIN or FINISH is ignored.
- FIFO behaviour:
  - host_valid_o = ~empty.
  - Pop occurs on host_valid_o & host_ready_i.
  - host_data_o/host_last_o come from the head entry, registered storage.
  - Push-to-host latency is 1 cycle: data pushed at edge k is visible after edge k.
  - Simultaneous push and pop is legal when not full and not empty.
  - When full, no push is issued (yumi held low) even if a pop occurs the same cycle.
  - Pointers wrap modulo els_p; full/empty use an extra pointer bit.
- host_data_o is undefined-but-stable while host_valid_o=0; the implementation drives the last written entry.
- busy_o = (state != IDLE). count_o saturates at N.

Decomposition:
- systolic_pkg (shared):
  - drain_state_e enum {IDLE, FLUSH, DRAIN, FINISH, ERR}
  - function for $clog2(N+1) width
- One sub-module, systolic_drain_fifo:
  - parameters width_p+1 and els_p
  - ports: push, pop, clear, full, empty, head data
  - same async active-low reset
- The FSM, counters and handshake glue stay in systolic_drain_ctrl.

Test Plan:
- Basic burst: start_i pulse, array presents 64 results 1..64 back-to-back, host_ready_i=1 -> flush_o high exactly 1 cycle; 64 yumis; host sees 1..64 in order; host_last_o only on 64; done_o pulses once; count_o=64.
- Backpressure: host_ready_i=0 for 20 cycles mid-burst -> FIFO fills to 4, arr_yumi_o=0 while arr_valid_i=1, no data lost or duplicated, resumes in order.
- Timeout: array presents 10 results then stops, timeout_p=16 -> ERR 16 cycles after 10th yumi; timeout_o=1; the 10 results still reach the host; start_i clears timeout_o and re-issues flush_o.
- Over-supply: array keeps arr_valid_i=1 after the 64th result -> arr_yumi_o stays 0 in FINISH/IDLE; exactly 64 entries delivered.
- Ignored start: start_i pulsed during DRAIN -> no second flush_o, count_o unaffected.
- Async reset mid-burst: reset_i low at result 30 -> all outputs 0 immediately without a clock edge; FIFO empty after release; a fresh start_i runs a clean 64-result burst.
